// File: rtl/range_sum_caller.sv
// rtl/range_sum_caller.sv - caller FSM that launches a range generator and sums every value it yields
//
// Purpose:
//   Captures base/limit/step on _start, pulses gen_start once, accumulates a
//   wrapping sum and count of every gen_valid value until gen_ready (or a
//   watchdog abort), then offers the result upstream with _valid/_wait/_ready.
//
// Ports:
//   _clock, _reset          clock (rising edge), synchronous active-low reset
//   _start, base/limit/step call request and its arguments (captured in IDLE)
//   _wait                   upstream backpressure while the result is offered
//   _valid, _0, _1, _err    result: sum, count, watchdog-abort flag
//   _ready                  one-cycle call-complete pulse
//   gen_base/limit/step     generator arguments, held from LAUNCH until IDLE
//   gen_start, gen_wait     generator start pulse and pause request
//   gen_valid, gen_0        generator value strobe and value
//   gen_ready               generator finished
//
// Optional feature macro: RANGE_CALLER_STALL_EN
//   When defined, gen_wait is raised on every STALL_PERIOD-th COLLECT cycle.

module range_sum_caller #(
  parameter int WIDTH        = 32,
  parameter int TIMEOUT      = 64,
  parameter int STALL_PERIOD = 4
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  input  logic             _wait,
  output logic             _valid,
  output logic             _ready,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1,
  output logic             _err,
  output logic [WIDTH-1:0] gen_base,
  output logic [WIDTH-1:0] gen_limit,
  output logic [WIDTH-1:0] gen_step,
  output logic             gen_start,
  output logic             gen_wait,
  input  logic             gen_valid,
  input  logic             gen_ready,
  input  logic [WIDTH-1:0] gen_0
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    COLLECT = 3'd2,
    RESULT  = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Watchdog counts 0..TIMEOUT-1 idle cycles; abort on the TIMEOUT-th.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] count;
  logic             err;
  logic [WD_W-1:0]  wd;
  logic             stall;
  logic             idle_cycle;
  logic             timeout_hit;

`ifdef RANGE_CALLER_STALL_EN
  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((STALL_PERIOD > 0) ? STALL_PERIOD - 1 : 0);

  logic [SC_W-1:0] stall_cnt;

  // Held at zero outside COLLECT so every call starts its stall pattern fresh.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      stall_cnt <= '0;
    end else if (state != COLLECT) begin
      stall_cnt <= '0;
    end else if (stall_cnt == SC_LAST) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + SC_W'(1);
    end
  end

  assign stall = (state == COLLECT) && (stall_cnt == SC_LAST);
`else
  // Feature compiled out: a period can never be negative, so this is constant 0.
  assign stall = (STALL_PERIOD < 0);
`endif

  // A stalled cycle is our own doing, so it never counts toward the watchdog.
  assign idle_cycle  = !gen_valid && !gen_ready && !stall;
  assign timeout_hit = (TIMEOUT != 0) && idle_cycle && (wd == WD_LAST);

  always_ff @(posedge _clock) begin
    if (!_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    _valid     = 1'b0;
    _ready     = 1'b0;
    _0         = '0;
    _1         = '0;
    _err       = 1'b0;
    gen_start  = 1'b0;
    gen_wait   = 1'b0;
    case (state)
      IDLE: begin
        if (_start) state_next = LAUNCH;
      end
      LAUNCH: begin
        gen_start  = 1'b1;
        state_next = COLLECT;
      end
      COLLECT: begin
        gen_wait = stall;
        if (gen_ready || timeout_hit) state_next = RESULT;
      end
      RESULT: begin
        _valid = 1'b1;
        _0     = sum;
        _1     = count;
        _err   = err;
        if (!_wait) state_next = DONE;
      end
      DONE: begin
        _ready     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (!_reset) begin
      gen_base  <= '0;
      gen_limit <= '0;
      gen_step  <= '0;
      sum       <= '0;
      count     <= '0;
      err       <= 1'b0;
      wd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (_start) begin
            gen_base  <= base;
            gen_limit <= limit;
            gen_step  <= step;
            sum       <= '0;
            count     <= '0;
            err       <= 1'b0;
            wd        <= '0;
          end
        end
        COLLECT: begin
          // A value arriving together with gen_ready is still counted.
          if (gen_valid) begin
            sum   <= sum + gen_0;
            count <= count + WIDTH'(1);
          end
          if (gen_valid || gen_ready) begin
            wd <= '0;
          end else if (!stall) begin
            wd <= wd + WD_W'(1);
          end
          if (timeout_hit) err <= 1'b1;
        end
        DONE: begin
          gen_base  <= '0;
          gen_limit <= '0;
          gen_step  <= '0;
          sum       <= '0;
          count     <= '0;
          err       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
